// File: rtl/pipe_adder_pkg.sv
// Shared constants for the pipelined adder: operation modes and the
// parameter-legality checks used at elaboration time.
package pipe_adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    localparam int MIN_WIDTH  = 8;
    localparam int MAX_WIDTH  = 64;
    localparam int MIN_STAGES = 1;
    localparam int MAX_STAGES = 4;

    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

    function automatic bit stages_ok(input int s);
        return (s >= MIN_STAGES) && (s <= MAX_STAGES);
    endfunction

    function automatic bit divisible_ok(input int w, input int s);
        return (s > 0) && ((w % s) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// Combinational ripple adder for one slice of the pipelined datapath;
// the carry-in lets consecutive slices be chained across pipeline stages.
module adder_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum   = total[W-1:0];
    assign cout  = total[W];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: one WIDTH/STAGES-bit slice is added per stage,
// with a global valid/ready handshake that freezes the whole pipe on a stall.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int SW = WIDTH / STAGES;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("pipe_adder: WIDTH must be within 8..64");
    end
    if (!stages_ok(STAGES)) begin : g_bad_stages
        $error("pipe_adder: STAGES must be within 1..4");
    end
    if (!divisible_ok(WIDTH, STAGES)) begin : g_bad_split
        $error("pipe_adder: WIDTH must be divisible by STAGES");
    end

    logic stall;
    logic a_msb;
    logic b_msb;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Stage k adds slice k. Each stage register keeps the finished low sum
    // bits plus only the operand bits later stages still need; the last
    // stage keeps just the operand MSBs for the overflow decision.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int CW   = WIDTH - k * SW;
        localparam bit LAST = (k == STAGES - 1);
        localparam int UW   = LAST ? 1 : CW - SW;
        localparam int HI   = (k + 1) * SW;

        logic [CW-1:0] a_cur;
        logic [CW-1:0] b_cur;
        logic          cin_cur;
        logic          vld_cur;
        logic [SW-1:0] slice_sum;
        logic          slice_cout;
        logic [HI-1:0] sum_next;
        logic [UW-1:0] a_keep;
        logic [UW-1:0] b_keep;

        logic          vld_q;
        logic          carry_q;
        logic [HI-1:0] sum_q;
        logic [UW-1:0] a_q;
        logic [UW-1:0] b_q;

        if (k == 0) begin : g_first
            assign a_cur    = A;
            assign b_cur    = (sub == SUB) ? ~B : B;
            assign cin_cur  = (sub == ADD) ? 1'b0 : 1'b1;
            assign vld_cur  = in_valid;
            assign sum_next = slice_sum;
        end else begin : g_next
            assign a_cur    = g_stage[k-1].a_q;
            assign b_cur    = g_stage[k-1].b_q;
            assign cin_cur  = g_stage[k-1].carry_q;
            assign vld_cur  = g_stage[k-1].vld_q;
            assign sum_next = {slice_sum, g_stage[k-1].sum_q};
        end

        if (LAST) begin : g_keep_msb
            assign a_keep = a_cur[CW-1];
            assign b_keep = b_cur[CW-1];
        end else begin : g_keep_hi
            assign a_keep = a_cur[CW-1:SW];
            assign b_keep = b_cur[CW-1:SW];
        end

        adder_slice #(.W(SW)) u_slice (
            .a    (a_cur[SW-1:0]),
            .b    (b_cur[SW-1:0]),
            .cin  (cin_cur),
            .sum  (slice_sum),
            .cout (slice_cout)
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q   <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
                a_q     <= '0;
                b_q     <= '0;
            end else if (!stall) begin
                vld_q   <= vld_cur;
                carry_q <= slice_cout;
                sum_q   <= sum_next;
                a_q     <= a_keep;
                b_q     <= b_keep;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign result    = g_stage[STAGES-1].sum_q;
    assign carry_out = g_stage[STAGES-1].carry_q;
    assign a_msb     = g_stage[STAGES-1].a_q[0];
    assign b_msb     = g_stage[STAGES-1].b_q[0];

    // Flags are qualified by out_valid so a freshly reset pipe reports 0.
    assign overflow = out_valid && (a_msb == b_msb) && (result[WIDTH-1] != a_msb);
    assign zero     = out_valid && (result == '0);

endmodule
